// File: rtl/vram_port_arbiter_if.sv
// Bus bundle between the VRAM port arbiter, its VGA/CPU clients and the
// single-port VRAM. The arbiter connects through the slave modport.
interface vram_port_arbiter_if #(
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 12,
    parameter int FIFO_DEPTH = 4
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    // Display scan port
    logic              vga_rdn;
    logic [ADDR_W-1:0] vga_addr;
    logic [DATA_W-1:0] vga_data;

    // CPU write port
    logic              cpu_wr_req;
    logic [ADDR_W-1:0] cpu_wr_addr;
    logic [DATA_W-1:0] cpu_wr_data;
    logic              cpu_wr_ready;

    // CPU read port
    logic              cpu_rd_req;
    logic [ADDR_W-1:0] cpu_rd_addr;
    logic              cpu_rd_busy;
    logic              cpu_rd_valid;
    logic [DATA_W-1:0] cpu_rd_data;

    // Status
    logic [LVL_W-1:0]  fifo_level;
    logic              wr_ovf;

    // VRAM side
    logic [ADDR_W-1:0] vram_addr;
    logic              vram_we;
    logic [DATA_W-1:0] vram_din;
    logic [DATA_W-1:0] vram_dout;

    modport slave (
        input  vga_rdn, vga_addr,
        input  cpu_wr_req, cpu_wr_addr, cpu_wr_data,
        input  cpu_rd_req, cpu_rd_addr,
        input  vram_dout,
        output vga_data, cpu_wr_ready, cpu_rd_busy, cpu_rd_valid, cpu_rd_data,
        output fifo_level, wr_ovf,
        output vram_addr, vram_we, vram_din
    );

    modport master (
        output vga_rdn, vga_addr,
        output cpu_wr_req, cpu_wr_addr, cpu_wr_data,
        output cpu_rd_req, cpu_rd_addr,
        output vram_dout,
        input  vga_data, cpu_wr_ready, cpu_rd_busy, cpu_rd_valid, cpu_rd_data,
        input  fifo_level, wr_ovf,
        input  vram_addr, vram_we, vram_din
    );
endinterface

// File: rtl/vram_port_arbiter.sv
// VRAM port arbiter: the display scan owns the single VRAM port whenever it
// requests; buffered CPU writes drain during blanking, and a single
// outstanding CPU read is issued only once every earlier write has landed.
module vram_port_arbiter #(
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                vga_clk,
    input  logic                rst_n,
    vram_port_arbiter_if.slave  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    state_t            state, state_nxt;

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [LVL_W-1:0]  level;
    logic              fifo_empty, fifo_full;
    logic              push, pop, rd_issue;

    logic              rd_busy;
    logic [ADDR_W-1:0] rd_addr;
    logic              disp_d1;

    assign fifo_empty       = (level == '0);
    assign fifo_full        = (level == LVL_W'(FIFO_DEPTH));
    assign push             = bus.cpu_wr_req & ~fifo_full;
    assign bus.cpu_wr_ready = ~fifo_full;
    assign bus.fifo_level   = level;
    assign bus.cpu_rd_busy  = rd_busy;
    assign bus.vram_din     = fifo_data[rd_ptr];

    // State register
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: leave IDLE only when a CPU read is put on the port
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rd_issue) state_nxt = RD_WAIT;
            RD_WAIT: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Port grant: display first, then FIFO head write, then pending read
    always_comb begin
        bus.vram_addr = '0;
        bus.vram_we   = 1'b0;
        pop           = 1'b0;
        rd_issue      = 1'b0;
        if (!bus.vga_rdn) begin
            bus.vram_addr = bus.vga_addr;
        end else if (state == IDLE && !fifo_empty) begin
            bus.vram_addr = fifo_addr[rd_ptr];
            bus.vram_we   = 1'b1;
            pop           = 1'b1;
        end else if (state == IDLE && rd_busy) begin
            // busy while IDLE means accepted but not yet issued
            bus.vram_addr = rd_addr;
            rd_issue      = 1'b1;
        end
    end

    // Write FIFO payload storage
    // NOTE: the payload array has no reset; occupancy is tracked by the
    // reset pointers/level, so stale entries are never consumed.
    always_ff @(posedge vga_clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= bus.cpu_wr_addr;
            fifo_data[wr_ptr] <= bus.cpu_wr_data;
        end
    end

    // Write FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            bus.wr_ovf <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      level <= level + 1'b1;
            else if (pop && !push) level <= level - 1'b1;
            if (bus.cpu_wr_req && fifo_full) bus.wr_ovf <= 1'b1;
        end
    end

    // CPU read: accept, hold address, return data after the VRAM latency
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_busy          <= 1'b0;
            rd_addr          <= '0;
            bus.cpu_rd_valid <= 1'b0;
            bus.cpu_rd_data  <= '0;
        end else begin
            if (bus.cpu_rd_req && !rd_busy) begin
                rd_busy <= 1'b1;
                rd_addr <= bus.cpu_rd_addr;
            end else if (state == RD_WAIT) begin
                rd_busy <= 1'b0;
            end
            bus.cpu_rd_valid <= (state == RD_WAIT);
            if (state == RD_WAIT) bus.cpu_rd_data <= bus.vram_dout;
        end
    end

    // Display return pipe: tag the request, capture VRAM data a cycle later
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_d1      <= 1'b0;
            bus.vga_data <= '0;
        end else begin
            disp_d1      <= ~bus.vga_rdn;
            bus.vga_data <= disp_d1 ? bus.vram_dout : '0;
        end
    end
endmodule

// File: tb/tb_vram_port_arbiter.sv
// Self-checking bench for vram_port_arbiter: stub VRAM with 1-cycle read
// latency, scoreboard queues for display data, VRAM writes and CPU reads.
module tb_vram_port_arbiter;
    logic vga_clk = 1'b0;
    logic rst_n   = 1'b0;
    int   cyc     = 0;
    int   n_cmp   = 0;
    int   n_err   = 0;

    always #5 vga_clk = ~vga_clk;
    always @(posedge vga_clk) cyc <= cyc + 1;

    vram_port_arbiter_if bus ();

    vram_port_arbiter dut (
        .vga_clk (vga_clk),
        .rst_n   (rst_n),
        .bus     (bus.slave)
    );

    typedef struct {
        int          due;
        logic [11:0] val;
    } disp_exp_t;

    typedef struct {
        logic [18:0] addr;
        logic [11:0] data;
    } wr_exp_t;

    disp_exp_t   disp_q[$];
    wr_exp_t     wr_q[$];
    logic [11:0] rd_q[$];
    logic [11:0] ram     [logic [18:0]];
    logic [11:0] exp_mem [logic [18:0]];

    function automatic logic [11:0] ram_val(input logic [18:0] a);
        if (ram.exists(a)) return ram[a];
        return a[11:0];
    endfunction

    function automatic logic [11:0] exp_val(input logic [18:0] a);
        if (exp_mem.exists(a)) return exp_mem[a];
        return a[11:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Stub VRAM: unwritten words read back as addr[11:0]
    always @(posedge vga_clk) begin
        if (bus.vram_we) ram[bus.vram_addr] = bus.vram_din;
        bus.vram_dout <= ram_val(bus.vram_addr);
    end

    // Output monitor, sampled on the falling edge
    always @(negedge vga_clk) begin : mon
        disp_exp_t e;
        wr_exp_t   w;
        if (rst_n) begin
            if (disp_q.size() > 0 && disp_q[0].due == cyc) begin
                e = disp_q.pop_front();
                check("vga_data", bus.vga_data, e.val);
            end
            if (bus.vram_we) begin
                check("we_collision", bus.vga_rdn, 1'b1);
                if (wr_q.size() == 0) begin
                    check("we_spurious", bus.vram_we, 1'b0);
                end else begin
                    w = wr_q.pop_front();
                    check("wr_addr", bus.vram_addr, w.addr);
                    check("wr_data", bus.vram_din, w.data);
                end
            end
            if (bus.cpu_rd_valid) begin
                if (rd_q.size() == 0) check("rd_spurious", bus.cpu_rd_valid, 1'b0);
                else                  check("cpu_rd_data", bus.cpu_rd_data, rd_q.pop_front());
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge vga_clk);
        #1;
    endtask

    task automatic disp(input logic [18:0] a);
        bus.vga_rdn  = 1'b0;
        bus.vga_addr = a;
        disp_q.push_back('{due: cyc + 2, val: ram_val(a)});
    endtask

    task automatic cpu_write(input logic [18:0] a, input logic [11:0] d);
        bus.cpu_wr_req  = 1'b1;
        bus.cpu_wr_addr = a;
        bus.cpu_wr_data = d;
        if (bus.cpu_wr_ready) begin
            wr_q.push_back('{addr: a, data: d});
            exp_mem[a] = d;
        end
    endtask

    task automatic cpu_read(input logic [18:0] a);
        for (int i = 0; i < 200; i++) begin
            if (!bus.cpu_rd_busy) break;
            tick();
        end
        check("rd_accept_wait", bus.cpu_rd_busy, 1'b0);
        bus.cpu_rd_req  = 1'b1;
        bus.cpu_rd_addr = a;
        rd_q.push_back(exp_val(a));
    endtask

    task automatic wait_drain(input string tag);
        bus.vga_rdn = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (bus.fifo_level == 0 && !bus.cpu_rd_busy && disp_q.size() == 0 &&
                wr_q.size() == 0 && rd_q.size() == 0) break;
            tick();
        end
        check({tag, "_level"}, bus.fifo_level, 0);
        check({tag, "_pending"}, disp_q.size() + wr_q.size() + rd_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_vga_data"}, bus.vga_data, 0);
        check({tag, "_rd_valid"}, bus.cpu_rd_valid, 0);
        check({tag, "_rd_data"},  bus.cpu_rd_data, 0);
        check({tag, "_rd_busy"},  bus.cpu_rd_busy, 0);
        check({tag, "_level"},    bus.fifo_level, 0);
        check({tag, "_wr_ovf"},   bus.wr_ovf, 0);
        check({tag, "_vram_we"},  bus.vram_we, 0);
        check({tag, "_wr_ready"}, bus.cpu_wr_ready, 1);
    endtask

    // Async reset asserted mid-cycle; in-flight expectations are dropped
    task automatic do_reset();
        foreach (wr_q[i]) exp_mem.delete(wr_q[i].addr);
        disp_q.delete();
        wr_q.delete();
        rd_q.delete();
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst");
        tick();
        bus.vga_rdn    = 1'b1;
        bus.cpu_wr_req = 1'b0;
        bus.cpu_rd_req = 1'b0;
        rst_n          = 1'b1;
        tick(2);
        check("rst_release_vga_data", bus.vga_data, 0);
        check("rst_release_level", bus.fifo_level, 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        bus.vga_rdn     = 1'b1;
        bus.vga_addr    = '0;
        bus.cpu_wr_req  = 1'b0;
        bus.cpu_wr_addr = '0;
        bus.cpu_wr_data = '0;
        bus.cpu_rd_req  = 1'b0;
        bus.cpu_rd_addr = '0;
        tick(3);
        check_reset_outputs("init");
        rst_n = 1'b1;
        tick(2);

        // 1: reset mid-frame with buffered writes and a pending read
        for (int i = 0; i < 4; i++) begin
            disp(19'(700 + i));
            if (i < 2) cpu_write(19'(12'h300 + i), 12'(12'h111 * (i + 1)));
            else       bus.cpu_wr_req = 1'b0;
            if (i == 2) cpu_read(19'h300);
            else        bus.cpu_rd_req = 1'b0;
            tick();
        end
        bus.cpu_rd_req = 1'b0;
        disp(19'd710);
        check("pre_rst_level", bus.fifo_level, 2);
        check("pre_rst_busy", bus.cpu_rd_busy, 1);
        do_reset();
        tick(4);

        // 2: full display line, stub RAM returns addr[11:0]
        for (int i = 0; i < 640; i++) begin
            disp(19'(i));
            tick();
        end
        bus.vga_rdn = 1'b1;
        tick(3);
        check("line_drained", disp_q.size(), 0);

        // 6: push and pop on the same edge at level 2
        disp(19'd900); cpu_write(19'h40, 12'h0C1); tick();
        disp(19'd901); cpu_write(19'h41, 12'h0C2); tick();
        check("pp_level_before", bus.fifo_level, 2);
        bus.vga_rdn = 1'b1;
        cpu_write(19'h42, 12'h0C3);
        tick();
        bus.cpu_wr_req = 1'b0;
        disp(19'd902);
        check("pp_level_after", bus.fifo_level, 2);
        check("pp_wr_ovf", bus.wr_ovf, 0);
        tick();
        wait_drain("pp");

        // 4: write then read the same address within one blanking window
        cpu_write(19'h20, 12'hBCD);
        tick();
        bus.cpu_wr_req = 1'b0;
        cpu_read(19'h20);
        tick();
        bus.cpu_rd_req = 1'b0;
        check("raw_busy", bus.cpu_rd_busy, 1);
        wait_drain("raw");

        // 5: display read lands in the RD_WAIT cycle
        cpu_read(19'h20);
        tick();
        bus.cpu_rd_req = 1'b0;
        tick();
        disp(19'h150);
        tick();
        bus.vga_rdn = 1'b1;
        wait_drain("rdwait");

        // 3: fill FIFO during active video, overflow, then drain in blanking
        for (int i = 0; i < 4; i++) begin
            disp(19'(1000 + i));
            cpu_write(19'(8'h10 + i), 12'(12'hA00 + i));
            tick();
        end
        bus.cpu_wr_req = 1'b0;
        disp(19'd1004);
        check("full_level", bus.fifo_level, 4);
        check("full_ready", bus.cpu_wr_ready, 0);
        check("full_ovf_before", bus.wr_ovf, 0);
        cpu_write(19'h14, 12'hA04);
        tick();
        bus.cpu_wr_req = 1'b0;
        disp(19'd1005);
        check("ovf_set", bus.wr_ovf, 1);
        check("ovf_level", bus.fifo_level, 4);
        tick();
        bus.vga_rdn = 1'b1;
        tick(4);
        check("drain_level", bus.fifo_level, 0);
        check("drain_order_done", wr_q.size(), 0);
        check("ovf_sticky", bus.wr_ovf, 1);
        wait_drain("fill");

        // Reset clears the sticky overflow
        do_reset();
        check("ovf_cleared", bus.wr_ovf, 0);
        tick(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
